// File: rtl/tlm_batch_player.sv
// Batch buffer: loads beats while idle, then plays the stored batch out on a valid/ready stream.
// Optional macro PLAYER_LOOP_EN adds rep_i, which replays the batch rep_i+1 times per start.
module tlm_batch_player #(
    parameter int NUM        = 50,
    parameter int ITEM_WIDTH = 8,
    parameter int CH         = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_valid_i,
    input  logic [CH*ITEM_WIDTH-1:0] load_data_i,
    output logic                     load_ready_o,
    input  logic                     start_i,
`ifdef PLAYER_LOOP_EN
    input  logic [7:0]               rep_i,
`endif
    output logic                     m_valid_o,
    output logic [CH*ITEM_WIDTH-1:0] m_data_o,
    input  logic                     m_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(NUM+1)-1:0] level_o
);

    localparam int CNT_W = $clog2(NUM + 1);
    localparam int AW    = $clog2(NUM);
    localparam int DW    = CH * ITEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
    logic             m_valid_q, m_valid_d;
    logic [DW-1:0]    m_data_q, m_data_d;
`ifdef PLAYER_LOOP_EN
    logic [7:0]       rep_q, rep_d;
`endif

    // Storage is deliberately left unreset; only level_q decides what is valid.
    logic [DW-1:0]    mem_q [NUM];

    logic             load_fire;
    logic             xfer;
    logic             last_beat;
    logic [CNT_W-1:0] rd_nxt;

    assign load_ready_o = (state_q == IDLE) && (level_q < CNT_W'(NUM));
    assign load_fire    = load_valid_i && load_ready_o;
    assign xfer         = m_valid_q && m_ready_i;
    assign last_beat    = (rd_idx_q == (level_q - 1'b1));
    assign rd_nxt       = rd_idx_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            mem_q[level_q[AW-1:0]] <= load_data_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        rd_idx_d  = rd_idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
`ifdef PLAYER_LOOP_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    level_d = level_q + 1'b1;
                end
                // A load landing in the same cycle writes entry level_q (>0), so entry 0 is safe to read.
                if (start_i && (level_q != '0)) begin
                    state_d   = PLAY;
                    m_valid_d = 1'b1;
                    m_data_d  = mem_q[0];
                    rd_idx_d  = '0;
`ifdef PLAYER_LOOP_EN
                    rep_d     = rep_i;
`endif
                end
            end
            PLAY: begin
                if (xfer) begin
                    if (!last_beat) begin
                        rd_idx_d = rd_nxt;
                        m_data_d = mem_q[rd_nxt[AW-1:0]];
                    end
`ifdef PLAYER_LOOP_EN
                    else if (rep_q != 8'd0) begin
                        rep_d    = rep_q - 8'd1;
                        rd_idx_d = '0;
                        m_data_d = mem_q[0];
                    end
`endif
                    else begin
                        state_d   = DONE;
                        m_valid_d = 1'b0;
                        level_d   = '0;
                        rd_idx_d  = '0;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                level_d  = '0;
                rd_idx_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            level_q   <= '0;
            rd_idx_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
`ifdef PLAYER_LOOP_EN
            rep_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            rd_idx_q  <= rd_idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
`ifdef PLAYER_LOOP_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign busy_o    = (state_q == PLAY);
    assign done_o    = (state_q == DONE);
    assign level_o   = level_q;

endmodule

// File: tb/tb_tlm_batch_player.sv
// Scoreboard bench for tlm_batch_player: loaded beats are queued as expectations and popped on transfer.
module tb_tlm_batch_player;

    localparam int NUM   = 50;
    localparam int IW    = 8;
    localparam int CH    = 2;
    localparam int DW    = CH * IW;
    localparam int CNT_W = $clog2(NUM + 1);

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             load_valid_i = 1'b0;
    logic [DW-1:0]    load_data_i = '0;
    logic             load_ready_o;
    logic             start_i = 1'b0;
`ifdef PLAYER_LOOP_EN
    logic [7:0]       rep_i = 8'd0;
`endif
    logic             m_valid_o;
    logic [DW-1:0]    m_data_o;
    logic             m_ready_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] level_o;

    int checks = 0;
    int failures = 0;
    int mdl_level = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    tlm_batch_player #(.NUM(NUM), .ITEM_WIDTH(IW), .CH(CH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .start_i      (start_i),
`ifdef PLAYER_LOOP_EN
        .rep_i        (rep_i),
`endif
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .level_o      (level_o)
    );

    function automatic logic [DW-1:0] beat(input int k);
        return {8'(2 * k + 1), 8'(2 * k)};
    endfunction

    // Called #1 after a rising edge; leaves the bench #1 after the next one.
    task automatic load_beat(input logic [DW-1:0] d);
        load_valid_i = 1'b1;
        load_data_i  = d;
        checks++;
        if (load_ready_o !== (mdl_level < NUM)) begin
            failures++;
            $display("FAIL load_ready level=%0d got=%b want=%b", mdl_level, load_ready_o, (mdl_level < NUM));
        end
        if (mdl_level < NUM) begin
            exp_q.push_back(d);
            mdl_level++;
        end
        @(posedge clk_i); #1;
        load_valid_i = 1'b0;
    endtask

    task automatic start_play();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready toggles 1,0,1,0 starting on the first valid cycle.
    task automatic run_play(input int mode, input int exp_n);
        int n_xfer = 0;
        int n_done = 0;
        int done_cyc = -1;
        int cyc = 0;
        int want_cyc;
        logic stall = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] e;
        checks++;
        if (m_valid_o !== 1'b1 || busy_o !== 1'b1 || m_data_o !== exp_q[0]) begin
            failures++;
            $display("FAIL play_start valid=%b busy=%b data=%h want 1/1/%h", m_valid_o, busy_o, m_data_o, exp_q[0]);
        end
        while (cyc < 4 * exp_n + 20 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                checks++;
                if (level_o !== '0 || m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL done_state level=%0d valid=%b busy=%b want 0/0/0", level_o, m_valid_o, busy_o);
                end
            end
            if (stall) begin
                checks++;
                if (m_data_o !== held) begin
                    failures++;
                    $display("FAIL stall_stable got=%h want=%h", m_data_o, held);
                end
            end
            m_ready_i = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (m_valid_o === 1'b1 && m_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat got=%h want=none", m_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data_o !== e) begin
                        failures++;
                        $display("FAIL beat_data idx=%0d got=%h want=%h", n_xfer, m_data_o, e);
                    end
                end
                n_xfer++;
            end
            stall = (m_valid_o === 1'b1) && !m_ready_i;
            held  = m_data_o;
            @(posedge clk_i); #1;
            cyc++;
        end
        m_ready_i = 1'b0;
        mdl_level = 0;
        want_cyc = (mode == 0) ? exp_n : 2 * exp_n - 1;
        checks++;
        if (n_xfer != exp_n || n_done != 1 || done_cyc != want_cyc || exp_q.size() != 0) begin
            failures++;
            $display("FAIL play_summary xfers=%0d dones=%0d done_cyc=%0d left=%0d want %0d/1/%0d/0",
                     n_xfer, n_done, done_cyc, exp_q.size(), exp_n, want_cyc);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #2;
        checks++;
        if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || level_o !== '0 || m_data_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b busy=%b done=%b level=%0d data=%h want all 0",
                     m_valid_o, busy_o, done_o, level_o, m_data_o);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        checks++;
        if (load_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", load_ready_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_full_speed();
        for (int k = 0; k < NUM; k++) load_beat(beat(k));
        checks++;
        if (level_o !== CNT_W'(NUM)) begin
            failures++;
            $display("FAIL full_level got=%0d want=%0d", level_o, NUM);
        end
        start_play();
        run_play(0, NUM);
    endtask

    task automatic test_stall();
        for (int k = 0; k < NUM; k++) load_beat(beat(k));
        start_play();
        run_play(1, NUM);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < NUM; k++) load_beat(beat(k));
        load_beat(16'hDEAD);
        checks++;
        if (level_o !== CNT_W'(NUM) || load_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL overflow_level level=%0d ready=%b want %0d/0", level_o, load_ready_o, NUM);
        end
        start_play();
        run_play(0, NUM);
    endtask

    task automatic test_empty_start();
        start_play();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL empty_start cyc=%0d valid=%b busy=%b done=%b want 0/0/0", i, m_valid_o, busy_o, done_o);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_midplay_reset();
        logic [DW-1:0] e;
        for (int k = 0; k < 20; k++) load_beat(beat(k + 60));
        start_play();
        m_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            e = exp_q.pop_front();
            if (m_valid_o !== 1'b1 || m_data_o !== e) begin
                failures++;
                $display("FAIL midplay_beat idx=%0d valid=%b got=%h want=%h", i, m_valid_o, m_data_o, e);
            end
            @(posedge clk_i); #1;
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || level_o !== '0 || m_data_o !== '0) begin
            failures++;
            $display("FAIL midplay_reset valid=%b busy=%b done=%b level=%0d data=%h want all 0",
                     m_valid_o, busy_o, done_o, level_o, m_data_o);
        end
        m_ready_i = 1'b0;
        exp_q.delete();
        mdl_level = 0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done_o !== 1'b0 || load_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL post_reset cyc=%0d done=%b ready=%b want 0/1", i, done_o, load_ready_o);
            end
            @(posedge clk_i); #1;
        end
        for (int k = 0; k < 5; k++) load_beat(beat(k + 100));
        start_play();
        run_play(0, 5);
    endtask

    task automatic test_coincident_load();
        load_beat(16'hA1A0);
        load_beat(16'hB1B0);
        load_valid_i = 1'b1;
        load_data_i  = 16'hC1C0;
        start_i      = 1'b1;
        exp_q.push_back(16'hC1C0);
        mdl_level++;
        @(posedge clk_i); #1;
        load_valid_i = 1'b0;
        start_i      = 1'b0;
        run_play(0, 3);
    endtask

`ifdef PLAYER_LOOP_EN
    task automatic test_loop();
        load_beat(16'h0A0A);
        load_beat(16'h0B0B);
        load_beat(16'h0C0C);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(16'h0A0A);
            exp_q.push_back(16'h0B0B);
            exp_q.push_back(16'h0C0C);
        end
        rep_i = 8'd2;
        start_play();
        rep_i = 8'd0;
        run_play(0, 9);
    endtask
`endif

    initial begin
        test_reset();
        test_full_speed();
        test_stall();
        test_overflow();
        test_empty_start();
        test_midplay_reset();
        test_coincident_load();
`ifdef PLAYER_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlm_batch_player.md
TLM_BATCH_PLAYER -- requirements
Module: tlm_batch_player

Interface
REQ-001 SHALL have parameter NUM, default 50, meaning the maximum beats stored per batch (buffer depth, >=2).
REQ-002 SHALL have parameter ITEM_WIDTH, default 8, meaning bits per channel item.
REQ-003 SHALL have parameter CH, default 2, meaning channels (items) per beat.
REQ-004 SHALL derive CNT_W = ceil(log2(NUM+1)) internally; it is not user-set.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 reset_i  input  1  reset, asynchronous, active-high.
REQ-007 load_valid_i  input  1  load beat valid.
REQ-008 load_data_i  input  CH*ITEM_WIDTH  load beat; channel c occupies bits c*ITEM_WIDTH up to (c+1)*ITEM_WIDTH-1.
REQ-009 load_ready_o  output  1  buffer accepts a load beat this cycle.
REQ-010 start_i  input  1  request playback of the stored batch.
REQ-011 m_valid_o  output  1  output beat valid.
REQ-012 m_data_o  output  CH*ITEM_WIDTH  output beat, same channel packing as load_data_i.
REQ-013 m_ready_i  input  1  downstream accepts output beat.
REQ-014 busy_o  output  1  high while in PLAY.
REQ-015 done_o  output  1  one-cycle batch-complete pulse.
REQ-016 level_o  output  CNT_W  beats currently stored.

Function
REQ-017 SHALL implement states IDLE, PLAY, DONE; IDLE->PLAY on start_i with level_o>0; PLAY->DONE on last beat transfer; DONE->IDLE unconditionally next cycle.
REQ-018 In IDLE, load_ready_o SHALL be high iff level_o<NUM; a load occurs when load_valid_i and load_ready_o are both high, writing entry level_o and incrementing level_o.
REQ-019 At level_o==NUM (full), load_ready_o SHALL be low and load_valid_i SHALL have no effect.
REQ-020 load_ready_o SHALL be low in PLAY and DONE; loads there SHALL be refused.
REQ-021 start_i with level_o==0 SHALL be ignored (no PLAY, no done_o); start_i in PLAY or DONE SHALL be ignored.
REQ-022 m_valid_o SHALL rise the cycle after start_i is sampled, presenting entry 0; output is registered.
REQ-023 A transfer occurs on m_valid_o && m_ready_i; the read index then advances; m_data_o SHALL hold stable while m_valid_o is high and m_ready_i low.
REQ-024 With m_ready_i held high, beats SHALL transfer on consecutive cycles with no bubbles (NUM beats in NUM cycles).
REQ-025 On transfer of entry level_o-1, m_valid_o SHALL drop next cycle; done_o SHALL be high exactly that cycle (DONE); level_o and read index SHALL clear to 0 in DONE.
REQ-026 busy_o SHALL equal (state==PLAY).
REQ-027 A load coincident with start_i in IDLE SHALL be accepted and included in the batch.

Reset
REQ-028 reset_i high SHALL asynchronously force IDLE, level_o=0, read index 0, m_valid_o=0, m_data_o=0, done_o=0, busy_o=0; load_ready_o=1 after release.
REQ-029 Buffer contents SHALL NOT be reset; reset mid-PLAY SHALL abandon the batch with no done_o pulse.

Configuration
REQ-030 With macro PLAYER_LOOP_EN defined, an 8-bit input rep_i SHALL exist, sampled with start_i; the batch SHALL replay rep_i+1 times back-to-back (read index wraps level_o-1 -> 0 without bubble), done_o only after the final pass.
REQ-031 Without PLAYER_LOOP_EN, rep_i SHALL be absent and playback SHALL be a single pass.

Verification
REQ-032 Load 50 beats {ch0=2k, ch1=2k+1}, start, m_ready_i=1 -> 50 consecutive beats k=0..49 with matching data, done_o single pulse next cycle, level_o=0.
REQ-033 Same batch, m_ready_i toggling 1,0,1,0 -> 50 beats in order, m_data_o stable during every stall, done_o once.
REQ-034 Drive 51 load beats -> load_ready_o low after the 50th, level_o stays 50, 51st beat never played.
REQ-035 start_i with level_o=0 -> m_valid_o stays 0, done_o stays 0, busy_o stays 0.
REQ-036 Reset asserted after 10 beats transferred -> all outputs 0 immediately, level_o=0, no done_o; new load/start then plays normally.
REQ-037 PLAYER_LOOP_EN, 3 beats {A,B,C}, rep_i=2 -> 9 consecutive beats A,B,C,A,B,C,A,B,C, exactly one done_o.
